// File: rtl/cache_pkg.sv
// Shared types and default geometry for the set-associative cache array.
package cache_pkg;

    localparam int unsigned IDX_W_DEF  = 4;
    localparam int unsigned OFF_W_DEF  = 2;
    localparam int unsigned TAG_W_DEF  = 5;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned WAYS_DEF   = 2;

    // Encoding matches {comp, write} so the request decodes with a plain cast
    typedef enum logic [1:0] {
        ACC_RD = 2'b00,
        ACC_WR = 2'b01,
        CMP_RD = 2'b10,
        CMP_WR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OP    = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/cache_way.sv
// One way of the cache: tag, valid, dirty and data storage for every set.
// Reads are combinational; valid/dirty reset in one cycle, tags/data are kept.
module cache_way #(
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned OFF_W  = 2,
    parameter int unsigned TAG_W  = 5,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  index,
    input  logic [OFF_W-1:0]  word,
    output logic [TAG_W-1:0]  rd_tag_c,
    output logic              rd_valid_c,
    output logic              rd_dirty_c,
    output logic [DATA_W-1:0] rd_data_c,
    input  logic              line_we,
    input  logic              word_we,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    input  logic              clr,
    input  logic [IDX_W-1:0]  clr_index
);
    localparam int unsigned SETS  = 1 << IDX_W;
    localparam int unsigned WORDS = 1 << OFF_W;

    logic [TAG_W-1:0]       tag_mem  [SETS];
    logic [DATA_W-1:0]      data_mem [SETS*WORDS];
    logic [SETS-1:0]        valid_q;
    logic [SETS-1:0]        dirty_q;
    logic [IDX_W+OFF_W-1:0] addr;

    assign addr       = {index, word};
    assign rd_tag_c   = tag_mem[index];
    assign rd_data_c  = data_mem[addr];
    assign rd_valid_c = valid_q[index];
    assign rd_dirty_c = dirty_q[index];

    // Tag and data storage: line fill writes both, compare-write only the word
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_mem[index] <= wr_tag;
            data_mem[addr] <= wr_data;
        end else if (word_we) begin
            data_mem[addr] <= wr_data;
        end
    end

    // Valid/dirty flags: reset and flush clear, line fill loads, word write dirties
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (clr) begin
            valid_q[clr_index] <= 1'b0;
            dirty_q[clr_index] <= 1'b0;
        end else if (line_we) begin
            valid_q[index] <= wr_valid;
            dirty_q[index] <= 1'b0;
        end else if (word_we) begin
            dirty_q[index] <= 1'b1;
        end
    end

endmodule

// File: rtl/assoc_cache.sv
// N-way set-associative cache array with req/ack handshake and flush sweep.
// Optional hit/miss counters enabled by defining ASSOC_CACHE_STATS_EN.
module assoc_cache
    import cache_pkg::*;
#(
    parameter int unsigned IDX_W  = IDX_W_DEF,
    parameter int unsigned OFF_W  = OFF_W_DEF,
    parameter int unsigned TAG_W  = TAG_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned WAYS   = WAYS_DEF,
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              flush,
    input  logic [IDX_W-1:0]  index,
    input  logic [OFF_W-1:0]  word,
    input  logic              comp,
    input  logic              write,
    input  logic [TAG_W-1:0]  tag_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              busy,
    output logic              ack,
    output logic              hit,
    output logic              dirty,
    output logic              valid,
    output logic [TAG_W-1:0]  tag_out,
    output logic [DATA_W-1:0] data_out,
    output logic [WAY_W-1:0]  way_out
`ifdef ASSOC_CACHE_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
`endif
);
    localparam int unsigned SETS = 1 << IDX_W;

    state_t             state, state_next;
    logic               accept_c, flush_clr_c;
    logic [IDX_W-1:0]   r_index, fl_cnt;
    logic [OFF_W-1:0]   r_word;
    op_t                r_op;
    logic [TAG_W-1:0]   r_tag;
    logic [DATA_W-1:0]  r_data;
    logic               r_valid;
    logic [WAY_W-1:0]   ptr [SETS];

    logic [TAG_W-1:0]   way_tag_c   [WAYS];
    logic [DATA_W-1:0]  way_data_c  [WAYS];
    logic [WAYS-1:0]    way_valid_c, way_dirty_c;
    logic [WAYS-1:0]    line_we_c, word_we_c;
    logic               hit_any_c, has_inv_c, is_cmp_c;
    logic [WAY_W-1:0]   hit_way_c, inv_way_c, victim_c, sel_c, ptr_inc_c;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        cache_way #(
            .IDX_W (IDX_W),
            .OFF_W (OFF_W),
            .TAG_W (TAG_W),
            .DATA_W(DATA_W)
        ) u_way (
            .clk       (clk),
            .rst       (rst),
            .index     (r_index),
            .word      (r_word),
            .rd_tag_c  (way_tag_c[g]),
            .rd_valid_c(way_valid_c[g]),
            .rd_dirty_c(way_dirty_c[g]),
            .rd_data_c (way_data_c[g]),
            .line_we   (line_we_c[g]),
            .word_we   (word_we_c[g]),
            .wr_tag    (r_tag),
            .wr_data   (r_data),
            .wr_valid  (r_valid),
            .clr       (flush_clr_c),
            .clr_index (fl_cnt)
        );
    end

    // Hit and victim priority encoding: lowest-numbered way wins
    always_comb begin
        hit_any_c = 1'b0;
        hit_way_c = '0;
        has_inv_c = 1'b0;
        inv_way_c = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (way_valid_c[w] && (way_tag_c[w] == r_tag)) begin
                hit_any_c = 1'b1;
                hit_way_c = WAY_W'(w);
            end
            if (!way_valid_c[w]) begin
                has_inv_c = 1'b1;
                inv_way_c = WAY_W'(w);
            end
        end
        victim_c  = has_inv_c ? inv_way_c : ptr[r_index];
        is_cmp_c  = (r_op == CMP_RD) || (r_op == CMP_WR);
        sel_c     = (is_cmp_c && hit_any_c) ? hit_way_c : victim_c;
        ptr_inc_c = (WAYS == 1) ? '0 : ptr[r_index] + WAY_W'(1);
    end

    // Per-way write strobes during the operation cycle
    always_comb begin
        line_we_c = '0;
        word_we_c = '0;
        if (state == OP) begin
            if (r_op == ACC_WR)
                line_we_c[victim_c] = 1'b1;
            if ((r_op == CMP_WR) && hit_any_c)
                word_we_c[hit_way_c] = 1'b1;
        end
    end

    // FSM next state; flush takes priority over req in IDLE
    always_comb begin
        state_next  = state;
        accept_c    = 1'b0;
        flush_clr_c = 1'b0;
        case (state)
            IDLE: begin
                if (flush) begin
                    state_next = FLUSH;
                end else if (req) begin
                    state_next = OP;
                    accept_c   = 1'b1;
                end
            end
            OP:    state_next = IDLE;
            FLUSH: begin
                flush_clr_c = 1'b1;
                if (fl_cnt == IDX_W'(SETS - 1))
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Request capture on acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_index <= '0;
            r_word  <= '0;
            r_op    <= ACC_RD;
            r_tag   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (accept_c) begin
            r_index <= index;
            r_word  <= word;
            r_op    <= op_t'({comp, write});
            r_tag   <= tag_in;
            r_data  <= data_in;
            r_valid <= valid_in;
        end
    end

    // Round-robin pointers and flush sweep counter
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) ptr[s] <= '0;
            fl_cnt <= '0;
        end else if (state == FLUSH) begin
            ptr[fl_cnt] <= '0;
            fl_cnt      <= (state_next == IDLE) ? '0 : fl_cnt + IDX_W'(1);
        end else if ((state == OP) && (r_op == ACC_WR)) begin
            ptr[r_index] <= ptr_inc_c;
        end
    end

    // Registered response; fields show pre-write contents and hold until next op
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            ack      <= 1'b0;
            hit      <= 1'b0;
            dirty    <= 1'b0;
            valid    <= 1'b0;
            tag_out  <= '0;
            data_out <= '0;
            way_out  <= '0;
        end else begin
            busy <= (state_next != IDLE);
            ack  <= (state == OP) || ((state == FLUSH) && (state_next == IDLE));
            if (state == OP) begin
                hit      <= is_cmp_c && hit_any_c;
                dirty    <= way_dirty_c[sel_c];
                valid    <= way_valid_c[sel_c];
                tag_out  <= way_tag_c[sel_c];
                data_out <= way_data_c[sel_c];
                way_out  <= sel_c;
            end
        end
    end

`ifdef ASSOC_CACHE_STATS_EN
    // Saturating hit/miss counters for compare operations
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if ((state == OP) && is_cmp_c) begin
            if (hit_any_c) begin
                if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            end else begin
                if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_assoc_cache.sv
// Scoreboard bench for assoc_cache: stimulus pushes expected responses,
// a negedge monitor pops and compares on every ack.
module tb_assoc_cache;

    logic        clk = 1'b0;
    logic        rst, req, flush, comp, write, valid_in;
    logic [3:0]  index;
    logic [1:0]  word;
    logic [4:0]  tag_in;
    logic [15:0] data_in;
    logic        busy, ack, hit, dirty, valid;
    logic [4:0]  tag_out;
    logic [15:0] data_out;
    logic        way_out;
`ifdef ASSOC_CACHE_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        bit          is_flush;
        bit          chk_td;
        logic        hit;
        logic        dirty;
        logic        valid;
        logic        way;
        logic [4:0]  tag;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    assoc_cache dut (
        .clk(clk), .rst(rst), .req(req), .flush(flush), .index(index), .word(word),
        .comp(comp), .write(write), .tag_in(tag_in), .data_in(data_in), .valid_in(valid_in),
        .busy(busy), .ack(ack), .hit(hit), .dirty(dirty), .valid(valid),
        .tag_out(tag_out), .data_out(data_out), .way_out(way_out)
`ifdef ASSOC_CACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    function automatic exp_t mk(string nm, logic h, logic d, logic v, logic wy,
                                bit ct, logic [4:0] t, logic [15:0] dt);
        exp_t e;
        e.name = nm; e.is_flush = 1'b0; e.chk_td = ct;
        e.hit = h; e.dirty = d; e.valid = v; e.way = wy; e.tag = t; e.data = dt;
        return e;
    endfunction

    // Monitor: every ack must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (ack) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got ack=1 want no ack");
            end else begin
                mon_e = sb.pop_front();
                if (!mon_e.is_flush) begin
                    chk({mon_e.name, ".hit"},   32'(hit),   32'(mon_e.hit));
                    chk({mon_e.name, ".dirty"}, 32'(dirty), 32'(mon_e.dirty));
                    chk({mon_e.name, ".valid"}, 32'(valid), 32'(mon_e.valid));
                    chk({mon_e.name, ".way"},   32'(way_out), 32'(mon_e.way));
                    if (mon_e.chk_td) begin
                        chk({mon_e.name, ".tag"},  32'(tag_out),  32'(mon_e.tag));
                        chk({mon_e.name, ".data"}, 32'(data_out), 32'(mon_e.data));
                    end
                end else begin
                    chk({mon_e.name, ".busy_at_ack"}, 32'(busy), 32'd0);
                end
            end
        end
    end

    task automatic op(input logic c, input logic w, input logic [3:0] idx,
                      input logic [1:0] wd, input logic [4:0] tg, input logic [15:0] dt,
                      input logic vin, input exp_t e);
        int n;
        sb.push_back(e);
        @(negedge clk);
        comp = c; write = w; index = idx; word = wd; tag_in = tg; data_in = dt;
        valid_in = vin; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk({e.name, ".busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({e.name, ".latency"}, 32'(n), 32'd1);
    endtask

    task automatic start_flush(input string nm, input bit expect_ack);
        exp_t e;
        e = mk(nm, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h0, 16'h0);
        e.is_flush = 1'b1;
        if (expect_ack) sb.push_back(e);
        @(negedge clk);
        flush = 1'b1;
        req   = 1'b1;
        comp = 1'b0; write = 1'b1; index = 4'd7; tag_in = 5'h11; valid_in = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        req   = 1'b0;
    endtask

    initial begin
        int n, nb;
        rst = 1'b1; req = 1'b0; flush = 1'b0; comp = 1'b0; write = 1'b0;
        valid_in = 1'b0; index = '0; word = '0; tag_in = '0; data_in = '0;
        repeat (2) @(negedge clk);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.ack", 32'(ack), 32'd0);
        chk("rst.hit", 32'(hit), 32'd0);
        chk("rst.dirty", 32'(dirty), 32'd0);
        chk("rst.valid", 32'(valid), 32'd0);
        chk("rst.tag_out", 32'(tag_out), 32'd0);
        chk("rst.data_out", 32'(data_out), 32'd0);
        chk("rst.way_out", 32'(way_out), 32'd0);
        rst = 1'b0;

        // Cold miss, fill, hit, compare-write, reads
        op(1, 0, 4'd3, 2'd1, 5'h0A, 16'h0, 0, mk("cold_rd", 0, 0, 0, 0, 0, 5'h0, 16'h0));
        op(0, 1, 4'd3, 2'd1, 5'h0A, 16'hBEEF, 1, mk("fill_w0", 0, 0, 0, 0, 0, 5'h0, 16'h0));
        op(1, 0, 4'd3, 2'd1, 5'h0A, 16'h0, 0, mk("hit_rd", 1, 0, 1, 0, 1, 5'h0A, 16'hBEEF));
        op(1, 1, 4'd3, 2'd1, 5'h0A, 16'h1234, 0, mk("cmp_wr", 1, 0, 1, 0, 1, 5'h0A, 16'hBEEF));
        op(1, 0, 4'd3, 2'd1, 5'h0A, 16'h0, 0, mk("dirty_rd", 1, 1, 1, 0, 1, 5'h0A, 16'h1234));
        op(0, 1, 4'd3, 2'd1, 5'h0B, 16'h0B0B, 1, mk("fill_w1", 0, 0, 0, 1, 0, 5'h0, 16'h0));
        // Set full: replacement follows the round-robin pointer
        op(0, 1, 4'd3, 2'd1, 5'h0C, 16'hCCCC, 1, mk("rr_w0", 0, 1, 1, 0, 1, 5'h0A, 16'h1234));
        op(0, 1, 4'd3, 2'd1, 5'h0D, 16'hDDDD, 1, mk("rr_w1", 0, 0, 1, 1, 1, 5'h0B, 16'h0B0B));
        op(1, 0, 4'd3, 2'd1, 5'h0C, 16'h0, 0, mk("hit_0c", 1, 0, 1, 0, 1, 5'h0C, 16'hCCCC));
        op(1, 0, 4'd3, 2'd1, 5'h0D, 16'h0, 0, mk("hit_0d", 1, 0, 1, 1, 1, 5'h0D, 16'hDDDD));
        op(1, 1, 4'd3, 2'd1, 5'h0E, 16'hFFFF, 0, mk("wr_miss", 0, 0, 1, 0, 1, 5'h0C, 16'hCCCC));
        op(0, 0, 4'd3, 2'd1, 5'h00, 16'h0, 0, mk("acc_rd", 0, 0, 1, 0, 1, 5'h0C, 16'hCCCC));
        op(0, 1, 4'd15, 2'd3, 5'h1F, 16'h5A5A, 1, mk("fill_s15", 0, 0, 0, 0, 0, 5'h0, 16'h0));
        op(1, 0, 4'd15, 2'd3, 5'h1F, 16'h0, 0, mk("hit_s15", 1, 0, 1, 0, 1, 5'h1F, 16'h5A5A));

        // Full flush with a simultaneous req that must be dropped
        start_flush("flush", 1'b1);
        n = 0; nb = 0;
        while (!ack && n < 40) begin
            if (busy) nb++;
            @(negedge clk);
            n++;
        end
        chk("flush.ack_edge", 32'(n), 32'd16);
        chk("flush.busy_cycles", 32'(nb), 32'd16);
        repeat (3) @(negedge clk);
        chk("flush.req_dropped", 32'(busy), 32'd0);
        op(1, 0, 4'd3, 2'd1, 5'h0C, 16'h0, 0, mk("post_fl_s3", 0, 0, 0, 0, 1, 5'h0C, 16'hCCCC));
        op(1, 0, 4'd15, 2'd3, 5'h1F, 16'h0, 0, mk("post_fl_s15", 0, 0, 0, 0, 1, 5'h1F, 16'h5A5A));

        // Reset in the middle of a flush sweep
        op(0, 1, 4'd9, 2'd0, 5'h03, 16'h0909, 1, mk("fill_s9", 0, 0, 0, 0, 0, 5'h0, 16'h0));
        start_flush("flush_abort", 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.ack", 32'(ack), 32'd0);
        chk("abort.valid", 32'(valid), 32'd0);
`ifdef ASSOC_CACHE_STATS_EN
        chk("abort.hit_cnt", 32'(hit_cnt), 32'd0);
        chk("abort.miss_cnt", 32'(miss_cnt), 32'd0);
`endif
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort.idle", 32'(busy), 32'd0);
        op(1, 0, 4'd9, 2'd0, 5'h03, 16'h0, 0, mk("post_rst_s9", 0, 0, 0, 0, 1, 5'h03, 16'h0909));

        repeat (2) @(negedge clk);
        chk("sb.empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/assoc_cache.md
# assoc_cache

Parametrised N-way set-associative cache array: successor of the single-level direct-mapped cache used by the memory-system controller. Each request carries set index, word offset, tag and data, and performs one of four operations (compare-read, compare-write, access-read, access-write) with a clocked req/ack handshake. Victim selection uses first-invalid, then a per-set round-robin pointer. Adds a multi-cycle flush sweep, which the direct-mapped version does not have.

## Interface
- IDX_W, 4, set index width; SETS = 2**IDX_W
- OFF_W, 2, word-offset width; WORDS = 2**OFF_W per line
- TAG_W, 5, tag width
- DATA_W, 16, data word width
- WAYS, 2, associativity; power of two, 1..8
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  1  request strobe; sampled only when busy=0
- flush  in  1  flush strobe; sampled only when busy=0; has priority over req
- index  in  IDX_W  set index
- word  in  OFF_W  word offset
- comp  in  1  1 = compare mode, 0 = access mode
- write  in  1  1 = write, 0 = read
- tag_in  in  TAG_W  request tag
- data_in  in  DATA_W  write data
- valid_in  in  1  valid bit written by access-write
- busy  out  1  operation or flush in progress
- ack  out  1  one-cycle completion pulse
- hit  out  1  compare hit
- dirty  out  1  dirty bit of the selected way
- valid  out  1  valid bit of the selected way
- tag_out  out  TAG_W  tag of the selected way
- data_out  out  DATA_W  selected word of the selected way
- way_out  out  clog2(WAYS) (min 1)  selected way

## Operation
- Request capture: all request inputs are registered when the request is accepted. Inputs are ignored while busy=1.
- Selected way:
  - Compare: the matching way if hit, else the victim.
  - Access: always the victim.
- Victim: lowest-numbered way with valid=0; if all ways are valid, the way given by the set's round-robin pointer.
- Compare-read: hit = valid & tag match. Returns the selected way's fields.
- Compare-write:
  - On hit: write data_in to the word and set dirty=1.
  - On miss: no state change, hit=0, return the victim's fields (for writeback).
- Access-read: return the victim's fields; hit=0; no state change.
- Access-write: into the victim write tag_in, the data word, and valid=valid_in; clear dirty; advance that set's pointer by 1 mod WAYS.
- Outputs show old contents. Read fields return the values before any write performed by the same operation.
- Flush: sweep sets 0..SETS-1, one per cycle, clearing valid, dirty and the pointer of every way. Data and tags are kept. ack pulses after the last set.
- State machine:
  - IDLE -> OP on req.
  - IDLE -> FLUSH on flush.
  - OP -> IDLE after 1 cycle.
  - FLUSH -> IDLE when the set counter reaches SETS-1.

## Timing
- Request accepted at edge k: busy=1 after edge k. At edge k+1 the op executes; ack=1, busy=0 and the outputs are valid after edge k+1 for exactly one cycle. Latency is 2 edges; one request per 2 cycles.
- Flush accepted at edge k: ack after edge k+SETS; busy high for SETS cycles.
- Simultaneous req and flush in IDLE: flush is taken and req is dropped.
- Outputs hold their last value until the next ack, except ack itself.
- Reset values:
  - State IDLE; busy, ack, hit, dirty, valid = 0.
  - tag_out, data_out, way_out = 0.
  - All valid, dirty and pointer bits = 0 in one cycle, no sweep.
- Reset mid-op or mid-flush: abort immediately. No ack; the array state is the reset state.
- Flush counter wraps only by termination and never exceeds SETS-1.

## Configuration
- ASSOC_CACHE_STATS_EN defined: adds outputs hit_cnt and miss_cnt, each 16 bits and saturating at 16'hFFFF.
  - Counted on every compare operation at its ack cycle.
  - Cleared by rst; not cleared by flush.
- Undefined: these ports and counters do not exist. Other behaviour is identical.

## Structure
- Package cache_pkg:
  - enum op_t {CMP_RD, CMP_WR, ACC_RD, ACC_WR}, decoded from {comp, write}.
  - State enum {IDLE, OP, FLUSH}.
  - Default width constants.
- Sub-module cache_way: one way's tag, valid, dirty and data storage, with read port, write enable and flush-clear port. Instantiated WAYS times via generate.
- Victim and hit priority encoding stays in the top level.

## Test plan
- Reset, then compare-read at index 3, tag 5'h0A -> ack after 2 edges; hit=0, valid=0, way_out=0.
- Access-write index 3, word 1, tag 5'h0A, data 16'hBEEF, valid_in=1; then compare-read of the same -> hit=1, data_out=16'hBEEF, dirty=0, way_out=0.
- Compare-write hit with data 16'h1234 -> dirty=1. A following compare-read -> 16'h1234, dirty=1.
- Fill both ways of set 3 (tags 5'h0A, 5'h0B), then access-write tag 5'h0C -> replaces way 0 (pointer); next access-write replaces way 1.
- Flush with SETS=16 -> busy for 16 cycles, ack at edge k+16. All compare-reads then miss.
- Assert rst during FLUSH at set 5 -> no ack; busy=0; all lines invalid. With STATS_EN, counters are 0.
